// File: rtl/uart_tx_wb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_wb_pkg
// Shared definitions for the Wishbone UART transmitter:
//   - register word offsets (adr_i[3:2])
//   - STATUS register bit positions
//   - transmit FSM state encoding
//   - sat_count(): clamps the FIFO occupancy into the 4-bit STATUS COUNT field
// -----------------------------------------------------------------------------
package uart_tx_wb_pkg;

    // Register word offsets, selected by adr_i[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    // STATUS bit positions
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // A 16-deep FIFO can hold 16 entries, which does not fit in 4 bits.
    function automatic logic [3:0] sat_count(input logic [31:0] count);
        return (count > 32'd15) ? 4'd15 : count[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_wb_if.sv
// -----------------------------------------------------------------------------
// uart_tx_wb_if
// Wishbone classic bus bundle for the UART transmitter slave port.
//   dat_i  32  write data          dat_o  32  read data (valid with ack_o)
//   adr_i  32  byte address        we_i    1  write enable
//   sel_i   4  byte selects        cyc_i   1  cycle
//   stb_i   1  strobe              ack_o   1  acknowledge
// Signal suffixes are from the slave's point of view.
// -----------------------------------------------------------------------------
interface uart_tx_wb_if;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [31:0] adr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        cyc_i;
    logic        stb_i;
    logic        ack_o;

    modport slave (
        input  dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
        output dat_o, ack_o
    );

    modport master (
        output dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
        input  dat_o, ack_o
    );
endinterface

// File: rtl/uart_tx_wb_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous show-ahead FIFO: rd_data always presents the oldest entry.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push, wr_data   write request and data
//   pop             remove the head entry (never requested while empty)
//   rd_data         head entry
//   full, empty     status, derived from pointers with one extra wrap bit
//   count           occupancy 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_wb.sv
// -----------------------------------------------------------------------------
// uart_tx_wb
// Wishbone classic slave UART transmitter, 8N1, with a TX FIFO.
//   clk_i   system clock
//   rst_ni  asynchronous reset, active-low
//   wb      Wishbone slave port (uart_tx_wb_if.slave)
//   tx_o    serial output, idle high
//   irq_o   high while the FIFO is empty and the transmitter is idle
// Register window (16 bytes at BASE_ADDR, word offset adr_i[3:2]):
//   0x0 TXDATA  W: queue dat_i[7:0] (sel_i[0]); dropped and OVF set when full
//   0x4 STATUS  R: [0]BUSY [1]FULL [2]EMPTY [3]OVF [7:4]COUNT; W: dat_i[3] clears OVF
//   0x8 BAUDDIV R/W [15:0], clocks per bit minus one, sampled at frame start
//   0xC reserved, reads 0
// -----------------------------------------------------------------------------
module uart_tx_wb
    import uart_tx_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0c00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    uart_tx_wb_if.slave   wb,
    output logic          tx_o,
    output logic          irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus / register state
    logic            ack_reg;
    logic [31:0]     dat_o_reg;
    logic [15:0]     baud_div_reg;
    logic            ovf_reg;

    // Transmitter state
    tx_state_t       state_reg;
    logic [15:0]     div_reg;
    logic [15:0]     timer_reg;
    logic [2:0]      bit_idx_reg;
    logic [7:0]      shift_reg;
    logic            tx_reg;

    logic            hit;
    logic            access;
    logic [1:0]      reg_off;
    logic            push_req;
    logic            ovf_clr;
    logic            baud_wr;
    logic [15:0]     baud_div_next;
    logic [31:0]     status_word;
    logic [31:0]     rd_data;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [7:0]      fifo_rd_data;
    logic [CW-1:0]   fifo_count;
    logic            busy;
    logic            bit_done;
    logic            unused_bits;

    // ------------------------------------------------------------------
    // Bus decode. access is true only on the edge that raises ack_o, so a
    // strobe held across several cycles acks (and acts) every other cycle.
    // ------------------------------------------------------------------
    assign hit      = wb.cyc_i & wb.stb_i & (wb.adr_i[31:4] == BASE_ADDR[31:4]);
    assign access   = hit & ~ack_reg;
    assign reg_off  = wb.adr_i[3:2];
    assign push_req = access & wb.we_i & (reg_off == REG_TXDATA) & wb.sel_i[0];
    assign ovf_clr  = access & wb.we_i & (reg_off == REG_STATUS) & wb.sel_i[0] & wb.dat_i[3];
    assign baud_wr  = access & wb.we_i & (reg_off == REG_BAUDDIV);

    assign unused_bits = ^{wb.adr_i[1:0], wb.dat_i[31:16], wb.sel_i[3:2]};

    always_comb begin
        baud_div_next = baud_div_reg;
        for (int b = 0; b < 2; b++) begin
            if (wb.sel_i[b]) baud_div_next[b*8 +: 8] = wb.dat_i[b*8 +: 8];
        end
    end

    assign busy = (state_reg != S_IDLE);

    always_comb begin
        status_word                          = '0;
        status_word[ST_BUSY]                 = busy;
        status_word[ST_FULL]                 = fifo_full;
        status_word[ST_EMPTY]                = fifo_empty;
        status_word[ST_OVF]                  = ovf_reg;
        status_word[ST_COUNT_LSB +: 4]       = sat_count(32'(fifo_count));
    end

    always_comb begin
        case (reg_off)
            REG_STATUS:  rd_data = status_word;
            REG_BAUDDIV: rd_data = {16'h0000, baud_div_reg};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_reg      <= 1'b0;
            dat_o_reg    <= '0;
            baud_div_reg <= DEFAULT_DIV;
            ovf_reg      <= 1'b0;
        end else begin
            ack_reg   <= access;
            dat_o_reg <= (access & ~wb.we_i) ? rd_data : '0;
            if (baud_wr) baud_div_reg <= baud_div_next;
            // A push into a full FIFO is only lost if nothing leaves this cycle.
            if (ovf_clr)
                ovf_reg <= 1'b0;
            else if (push_req & fifo_full & ~fifo_pop)
                ovf_reg <= 1'b1;
        end
    end

    assign wb.ack_o = ack_reg;
    assign wb.dat_o = dat_o_reg;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (push_req),
        .wr_data (wb.dat_i[7:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ------------------------------------------------------------------
    // Transmitter. A byte is taken from the FIFO when idle, or directly at
    // the end of a stop bit so consecutive frames have no gap.
    // ------------------------------------------------------------------
    assign bit_done = (timer_reg == div_reg);
    assign fifo_pop = ~fifo_empty &
                      ((state_reg == S_IDLE) | ((state_reg == S_STOP) & bit_done));

    // tx_reg is computed from the state of the previous cycle. Every bit keeps
    // its full div+1 width; the line simply trails the FSM by one clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= S_IDLE;
            div_reg     <= '0;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                S_START: tx_reg <= 1'b0;
                S_DATA:  tx_reg <= shift_reg[0];
                default: tx_reg <= 1'b1;
            endcase

            if (fifo_pop) begin
                shift_reg <= fifo_rd_data;
                div_reg   <= baud_div_reg;
                timer_reg <= '0;
                state_reg <= S_START;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        timer_reg <= '0;
                    end
                    S_START: begin
                        if (bit_done) begin
                            timer_reg   <= '0;
                            bit_idx_reg <= '0;
                            state_reg   <= S_DATA;
                        end else begin
                            timer_reg <= timer_reg + 16'd1;
                        end
                    end
                    S_DATA: begin
                        if (bit_done) begin
                            timer_reg   <= '0;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            if (bit_idx_reg == 3'd7) state_reg <= S_STOP;
                        end else begin
                            timer_reg <= timer_reg + 16'd1;
                        end
                    end
                    S_STOP: begin
                        if (bit_done) begin
                            timer_reg <= '0;
                            state_reg <= S_IDLE;
                        end else begin
                            timer_reg <= timer_reg + 16'd1;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_o  = tx_reg;
    assign irq_o = fifo_empty & ~busy;

endmodule

// File: tb/tb_uart_tx_wb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_wb
// Drives the UART transmitter over Wishbone and decodes tx_o cycle by cycle.
// Bytes are queued as expected frames when written; a line monitor pops them
// at each start bit and checks every clock of the frame against the ideal
// 8N1 waveform for the divider in force when the frame began.
// -----------------------------------------------------------------------------
module tb_uart_tx_wb;

    localparam logic [31:0] BASE = 32'h0000_0c00;

    logic clk_i;
    logic rst_ni;
    logic tx_o;
    logic irq_o;

    uart_tx_wb_if wbi ();

    uart_tx_wb #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wb     (wbi),
        .tx_o   (tx_o),
        .irq_o  (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard and serial-line monitor
    // ------------------------------------------------------------------
    logic [7:0] sb_q[$];
    int         start_q[$];
    int         tb_div = 867;
    int         frames_started = 0;
    bit         mon_active = 0;
    int         mon_cnt;
    int         mon_div;
    int         mon_bit;
    logic [7:0] mon_byte;
    logic       exp_bit;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mon_active = 0;
        end else begin
            if (!mon_active && tx_o === 1'b0) begin
                check_eq("sb_nonempty", sb_q.size() != 0, 1);
                mon_byte = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
                mon_div  = tb_div;
                mon_cnt  = 0;
                mon_active = 1;
                start_q.push_back(cyc_cnt);
                frames_started++;
            end
            if (mon_active) begin
                mon_bit = mon_cnt / (mon_div + 1);
                if (mon_bit == 0)      exp_bit = 1'b0;
                else if (mon_bit == 9) exp_bit = 1'b1;
                else                   exp_bit = mon_byte[mon_bit-1];
                check_eq("tx_bit", tx_o, exp_bit);
                mon_cnt++;
                if (mon_cnt == 10 * (mon_div + 1)) begin
                    $display("frame 0x%02h div=%0d done at cyc %0d", mon_byte, mon_div, cyc_cnt);
                    mon_active = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus helpers: each access starts just after a clock edge, expects ack
    // after one edge, then leaves one idle cycle.
    // ------------------------------------------------------------------
    task automatic wb_access(input logic [3:0] off, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat, output int ack_cyc);
        int waited;
        waited = 0;
        wbi.adr_i = BASE + {28'h0, off};
        wbi.we_i  = we;
        wbi.dat_i = dat;
        wbi.sel_i = sel;
        wbi.cyc_i = 1'b1;
        wbi.stb_i = 1'b1;
        do begin
            @(posedge clk_i); #1;
            waited++;
        end while (wbi.ack_o !== 1'b1 && waited < 8);
        rdat    = wbi.dat_o;
        ack_cyc = cyc_cnt;
        check_eq("ack_lat", waited, 1);
        wbi.cyc_i = 1'b0;
        wbi.stb_i = 1'b0;
        wbi.we_i  = 1'b0;
        $display("wb %s off=0x%0h dat=0x%08h sel=%b ack_cyc=%0d",
                 we ? "WR" : "RD", off, we ? dat : rdat, sel, ack_cyc);
        @(posedge clk_i); #1;
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel,
                            output int ack_cyc);
        logic [31:0] dummy;
        wb_access(off, 1'b1, dat, sel, dummy, ack_cyc);
    endtask

    task automatic wb_read(input logic [3:0] off, output logic [31:0] rdat);
        int ac;
        wb_access(off, 1'b0, 32'h0, 4'hf, rdat, ac);
    endtask

    task automatic wait_start(input int n_before);
        int k;
        k = 0;
        while (frames_started == n_before && k < 200) begin
            @(posedge clk_i); #1;
            k++;
        end
        check_eq("start_seen", frames_started != n_before, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(irq_o === 1'b1 && !mon_active) && k < budget) begin
            @(posedge clk_i); #1;
            k++;
        end
        check_eq("drained", irq_o === 1'b1 && !mon_active, 1);
        check_eq("sb_left", sb_q.size(), 0);
    endtask

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          ac;
        int          n;
        int          target;
        int          sz;

        rst_ni    = 1'b0;
        wbi.cyc_i = 1'b0;
        wbi.stb_i = 1'b0;
        wbi.we_i  = 1'b0;
        wbi.adr_i = '0;
        wbi.dat_i = '0;
        wbi.sel_i = '0;

        // Reset state and register defaults
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_tx", tx_o, 1);
        check_eq("rst_ack", wbi.ack_o, 0);
        check_eq("rst_dat", wbi.dat_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_eq("rst_irq", irq_o, 1);
        wb_read(4'h4, rd);  check_eq("rst_status", rd, 32'h04);
        wb_read(4'h8, rd);  check_eq("rst_baud", rd, 32'd867);
        wb_write(4'hc, 32'hffff_ffff, 4'hf, ac);
        wb_read(4'hc, rd);  check_eq("reserved_rd", rd, 0);

        // Byte selects on BAUDDIV, then a single 0x55 frame at div=3
        wb_write(4'h8, 32'hffff_ff07, 4'b0001, ac);
        wb_read(4'h8, rd);  check_eq("baud_sel_lo", rd, 32'h0307);
        wb_write(4'h8, 32'h0000_0003, 4'b0011, ac);
        tb_div = 3;
        wb_read(4'h8, rd);  check_eq("baud_div3", rd, 32'd3);
        sb_q.push_back(8'h55);
        n = frames_started;
        wb_write(4'h0, 32'h55, 4'b0001, ac);
        check_eq("irq_busy", irq_o, 0);
        wait_start(n);
        check_eq("tx_latency", start_q[start_q.size()-1] - ac, 2);
        wait_idle(200);
        check_eq("irq_idle", irq_o, 1);

        // Fill the FIFO, overflow, clear OVF
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'h10 + 8'(i);
            sb_q.push_back(b);
            wb_write(4'h0, {24'h0, b}, 4'b0001, ac);
        end
        wb_read(4'h4, rd);  check_eq("status_full", rd, 32'h83);
        wb_write(4'h0, 32'hee, 4'b0001, ac);
        wb_read(4'h4, rd);  check_eq("status_ovf", rd, 32'h8b);
        wb_write(4'h4, 32'h8, 4'b0001, ac);
        wb_read(4'h4, rd);  check_eq("status_ovf_clr", rd, 32'h83);

        // Push on the very edge the FSM pops the next byte while full
        target = start_q[start_q.size()-1] + 39;
        while (cyc_cnt < target - 1) begin
            @(posedge clk_i); #1;
        end
        sb_q.push_back(8'h3c);
        wb_write(4'h0, 32'h3c, 4'b0001, ac);
        check_eq("push_pop_edge", ac, target);
        wb_read(4'h4, rd);  check_eq("status_pushpop", rd, 32'h83);
        wait_idle(1000);

        // Held strobe: ack every other cycle, one push per ack
        sb_q.push_back(8'ha1);
        sb_q.push_back(8'ha2);
        wbi.adr_i = BASE;
        wbi.we_i  = 1'b1;
        wbi.sel_i = 4'b0001;
        wbi.dat_i = 32'ha1;
        wbi.cyc_i = 1'b1;
        wbi.stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            check_eq("held_ack", wbi.ack_o, (k % 2) == 0);
            if (k == 0) wbi.dat_i = 32'ha2;
        end
        $display("wb held WR off=0x0 two acks over 4 cycles");
        wbi.adr_i = 32'h0000_0400;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            check_eq("miss_ack", wbi.ack_o, 0);
        end
        $display("wb held WR adr=0x400 no ack");
        wbi.cyc_i = 1'b0;
        wbi.stb_i = 1'b0;
        wbi.we_i  = 1'b0;
        @(posedge clk_i); #1;
        wait_idle(300);

        // Divider change mid-frame applies to the next frame only
        sb_q.push_back(8'h0f);
        sb_q.push_back(8'hf0);
        n = frames_started;
        wb_write(4'h0, 32'h0f, 4'b0001, ac);
        wb_write(4'h0, 32'hf0, 4'b0001, ac);
        wait_start(n);
        repeat (8) begin
            @(posedge clk_i); #1;
        end
        wb_write(4'h8, 32'h1, 4'b0011, ac);
        tb_div = 1;
        wait_idle(300);
        sz = start_q.size();
        check_eq("no_gap", start_q[sz-1] - start_q[sz-2], 40);

        // Reset in the middle of a frame
        wb_write(4'h8, 32'h3, 4'b0011, ac);
        tb_div = 3;
        sb_q.push_back(8'h00);
        n = frames_started;
        wb_write(4'h0, 32'h00, 4'b0001, ac);
        wait_start(n);
        repeat (6) begin
            @(posedge clk_i); #1;
        end
        check_eq("pre_rst_tx", tx_o, 0);
        rst_ni = 1'b0;
        sb_q.delete();
        #1;
        check_eq("rst_mid_tx", tx_o, 1);
        check_eq("rst_mid_ack", wbi.ack_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tb_div = 867;
        @(posedge clk_i); #1;
        check_eq("rst_mid_irq", irq_o, 1);
        wb_read(4'h4, rd);  check_eq("rst_mid_status", rd, 32'h04);
        wb_read(4'h8, rd);  check_eq("rst_mid_baud", rd, 32'd867);
        repeat (5) @(posedge clk_i);
        #1;
        check_eq("rst_mid_line", tx_o, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
